// File: rtl/credit_flit_source.sv
// credit_flit_source: parametrised flit generator for one router input port.
// Emits header/body/tail packets under credit-based flow control, with a
// programmable inter-packet gap and a run-level packet count.
// Optional feature: define CREDIT_FLIT_SOURCE_LFSR_EN to fill body flits from
// a FLIT_W-bit Galois LFSR instead of the {sequence, flit index} pattern.
module credit_flit_source #(
  parameter int          FLIT_W       = 32,
  parameter int          ADDR_W       = 4,
  parameter int          PORT         = 0,
  parameter int          BUFFER_DEPTH = 4,
  parameter int          LEN_W        = 8,
  parameter logic [31:0] SEED         = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_dst_x,
  input  logic [ADDR_W-1:0] cfg_dst_y,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [LEN_W-1:0]  cfg_gap,
  input  logic [LEN_W-1:0]  cfg_num_pkts,
  input  logic              credit_in,
  output logic [FLIT_W-1:0] channel_out,
  output logic [1:0]        diff_pair_out,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  pkts_sent,
  output logic              credit_err
);

  localparam int                CRED_W       = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_FULL    = CRED_W'(BUFFER_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE     = CRED_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_TWO      = LEN_W'(2);
  localparam logic [2:0]        PORT_ID      = 3'(PORT);
  localparam int                HDR_Y_MSB    = FLIT_W - 1 - ADDR_W;
  localparam int                HDR_PORT_MSB = FLIT_W - 1 - 2 * ADDR_W;

  localparam logic [1:0] MARK_NONE = 2'b00;
  localparam logic [1:0] MARK_HEAD = 2'b10;
  localparam logic [1:0] MARK_BODY = 2'b11;
  localparam logic [1:0] MARK_TAIL = 2'b01;

  typedef enum logic [2:0] {IDLE, HEAD, BODY, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dst_x_q, dst_y_q;
  logic [LEN_W-1:0]  last_idx_q;
  logic [LEN_W-1:0]  gap_q;
  logic [LEN_W-1:0]  num_pkts_q;
  logic [LEN_W-1:0]  flit_idx_q;
  logic [LEN_W-1:0]  gap_cnt_q;
  logic [CRED_W-1:0] credits_q;

  logic              have_credit;
  logic              send;
  logic              tail;
  logic              start_run;
  logic              credit_drop;
  logic              credit_ok;
  logic [LEN_W-1:0]  pkts_inc;
  logic [7:0]        seq8;
  logic [FLIT_W-1:0] header_flit;
  logic [FLIT_W-1:0] body_data;
  logic [FLIT_W-1:0] flit_data;
  logic [1:0]        flit_mark;

  assign have_credit = (credits_q != '0);
  assign pkts_inc    = pkts_sent + LEN_ONE;
  assign seq8        = 8'(pkts_sent);
  assign credit_drop = credit_in && (credits_q == CRED_FULL) && !send;
  assign credit_ok   = credit_in && !credit_drop;

`ifdef CREDIT_FLIT_SOURCE_LFSR_EN
  // Galois feedback masks for the supported widths; other widths fall back
  // to a simple end-around tap so the register never locks up.
  function automatic logic [FLIT_W-1:0] lfsr_taps();
    logic [FLIT_W-1:0] t;
    t = '0;
    case (FLIT_W)
      16:      t = FLIT_W'(32'h0000_B400);
      24:      t = FLIT_W'(32'h00E1_0000);
      32:      t = FLIT_W'(32'h8020_0003);
      default: begin
        t[FLIT_W-1] = 1'b1;
        t[0]        = 1'b1;
      end
    endcase
    return t;
  endfunction

  localparam logic [FLIT_W-1:0] LFSR_TAPS = lfsr_taps();
  localparam logic [FLIT_W-1:0] LFSR_SEED = FLIT_W'(SEED);

  logic [FLIT_W-1:0] lfsr_q;

  // Payload generator: steps once per emitted body or tail flit, survives runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (send && (state_q == BODY)) begin
      lfsr_q <= {1'b0, lfsr_q[FLIT_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  assign body_data = lfsr_q;
`else
  assign body_data = FLIT_W'({seq8, flit_idx_q});
`endif

  // Header layout: dst_x at the top, then dst_y, then the port ID, seq byte at the bottom.
  always_comb begin
    header_flit                         = '0;
    header_flit[FLIT_W-1 -: ADDR_W]     = dst_x_q;
    header_flit[HDR_Y_MSB -: ADDR_W]    = dst_y_q;
    header_flit[HDR_PORT_MSB -: 3]      = PORT_ID;
    header_flit[7:0]                    = seq8;
  end

  // Next-state logic plus the per-cycle send decision and flit selection.
  always_comb begin
    state_d   = state_q;
    send      = 1'b0;
    tail      = 1'b0;
    start_run = 1'b0;
    flit_data = header_flit;
    flit_mark = MARK_NONE;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = (cfg_num_pkts == '0) ? DONE : HEAD;
        end
      end
      HEAD: begin
        if (have_credit) begin
          send      = 1'b1;
          flit_data = header_flit;
          flit_mark = MARK_HEAD;
          state_d   = BODY;
        end
      end
      BODY: begin
        if (have_credit) begin
          send      = 1'b1;
          flit_data = body_data;
          if (flit_idx_q == last_idx_q) begin
            tail      = 1'b1;
            flit_mark = MARK_TAIL;
            if (pkts_inc == num_pkts_q) begin
              state_d = DONE;
            end else if (gap_q != '0) begin
              state_d = GAP;
            end else begin
              state_d = HEAD;
            end
          end else begin
            flit_mark = MARK_BODY;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = HEAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q  <= CRED_FULL;
      credit_err <= 1'b0;
    end else begin
      if (send && !credit_ok) begin
        credits_q <= credits_q - CRED_ONE;
      end else if (!send && credit_ok) begin
        credits_q <= credits_q + CRED_ONE;
      end
      if (credit_drop) begin
        credit_err <= 1'b1;
      end
    end
  end

  // Run configuration latch, packet/flit/gap counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      last_idx_q <= LEN_ONE;
      gap_q      <= '0;
      num_pkts_q <= '0;
      flit_idx_q <= '0;
      gap_cnt_q  <= '0;
      pkts_sent  <= '0;
    end else begin
      if (start_run) begin
        dst_x_q    <= cfg_dst_x;
        dst_y_q    <= cfg_dst_y;
        last_idx_q <= (cfg_pkt_len < LEN_TWO) ? LEN_ONE : (cfg_pkt_len - LEN_ONE);
        gap_q      <= cfg_gap;
        num_pkts_q <= cfg_num_pkts;
        flit_idx_q <= '0;
        pkts_sent  <= '0;
      end
      if (send && (state_q == HEAD)) begin
        flit_idx_q <= LEN_ONE;
      end
      if (send && (state_q == BODY)) begin
        if (tail) begin
          flit_idx_q <= '0;
          pkts_sent  <= pkts_inc;
          if (gap_q != '0) begin
            gap_cnt_q <= gap_q - LEN_ONE;
          end
        end else begin
          flit_idx_q <= flit_idx_q + LEN_ONE;
        end
      end
      if ((state_q == GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - LEN_ONE;
      end
    end
  end

  // Registered outputs: flit channel, marker, and run status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      channel_out   <= '0;
      diff_pair_out <= MARK_NONE;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      diff_pair_out <= MARK_NONE;
      if (send) begin
        channel_out   <= flit_data;
        diff_pair_out <= flit_mark;
      end
      busy <= (state_d == HEAD) || (state_d == BODY) || (state_d == GAP);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_credit_flit_source.sv
// tb_credit_flit_source: randomized and directed bench for credit_flit_source
// with a packet-level reference model of the expected flit stream and timing.
module tb_credit_flit_source;

  localparam int          FLIT_W = 32;
  localparam int          ADDR_W = 4;
  localparam int          PORT   = 4;
  localparam int          BD     = 4;
  localparam int          LEN_W  = 8;
  localparam logic [31:0] SEED   = 32'hACE1_0001;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] cfg_dst_x, cfg_dst_y;
  logic [LEN_W-1:0]  cfg_pkt_len, cfg_gap, cfg_num_pkts;
  logic              credit_in;
  logic [FLIT_W-1:0] channel_out;
  logic [1:0]        diff_pair_out;
  logic              busy, done, credit_err;
  logic [LEN_W-1:0]  pkts_sent;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit auto_credit = 0;

  logic [1:0]  cap_mark[$];
  logic [31:0] cap_data[$];
  int          cap_cyc[$];
  logic [1:0]  exp_mark[$];
  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  logic [31:0] ref_lfsr;

  credit_flit_source #(
    .FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .PORT(PORT),
    .BUFFER_DEPTH(BD), .LEN_W(LEN_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_dst_x(cfg_dst_x), .cfg_dst_y(cfg_dst_y),
    .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
    .credit_in(credit_in),
    .channel_out(channel_out), .diff_pair_out(diff_pair_out),
    .busy(busy), .done(done), .pkts_sent(pkts_sent), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: outputs are observed and the next inputs driven on the falling edge.
  task automatic clock_cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    start = 1'b0;
    if (diff_pair_out != 2'b00) begin
      cap_mark.push_back(diff_pair_out);
      cap_data.push_back(channel_out);
      cap_cyc.push_back(cyc);
    end
    credit_in = auto_credit && (diff_pair_out != 2'b00);
  endtask

  task automatic clear_capture();
    cap_mark.delete();
    cap_data.delete();
    cap_cyc.delete();
  endtask

  // Reference model: full flit stream of one run assuming credits never run out.
  task automatic model_run(input int dx, input int dy, input int len, input int gap,
                           input int num, input int start_cyc);
    int eff;
    int t;
    logic [63:0] h;
    eff = (len < 2) ? 2 : len;
    t = start_cyc + 1;
    exp_mark.delete();
    exp_data.delete();
    exp_cyc.delete();
    for (int p = 0; p < num; p++) begin
      h = (64'(dx) << (FLIT_W - ADDR_W)) | (64'(dy) << (FLIT_W - 2 * ADDR_W)) |
          (64'(PORT) << (FLIT_W - 2 * ADDR_W - 3)) | 64'(p % 256);
      exp_mark.push_back(2'b10);
      exp_data.push_back(h[31:0]);
      exp_cyc.push_back(t);
      t++;
      for (int i = 1; i < eff; i++) begin
        exp_mark.push_back((i == eff - 1) ? 2'b01 : 2'b11);
`ifdef CREDIT_FLIT_SOURCE_LFSR_EN
        exp_data.push_back(ref_lfsr);
        ref_lfsr = (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 32'h8020_0003 : 32'h0);
`else
        exp_data.push_back(32'(((p % 256) << LEN_W) | (i % 256)));
`endif
        exp_cyc.push_back(t);
        t++;
      end
      t += gap;
    end
  endtask

  task automatic kick(input int dx, input int dy, input int len, input int gap, input int num);
    cfg_dst_x    = ADDR_W'(dx);
    cfg_dst_y    = ADDR_W'(dy);
    cfg_pkt_len  = LEN_W'(len);
    cfg_gap      = LEN_W'(gap);
    cfg_num_pkts = LEN_W'(num);
    start        = 1'b1;
    clear_capture();
    clock_cycle();
    model_run(dx, dy, len, gap, num, cyc);
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) clock_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; credit_in = 1'b0;
    cfg_dst_x = '0; cfg_dst_y = '0; cfg_pkt_len = '0; cfg_gap = '0; cfg_num_pkts = '0;
    ref_lfsr = SEED;
    #12;
    checks++; if (channel_out !== 32'h0) begin fails++; $display("[TB] FAIL rst_channel: got %h expected 0", channel_out); end
    checks++; if (diff_pair_out !== 2'b00) begin fails++; $display("[TB] FAIL rst_marker: got %b expected 00", diff_pair_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL rst_status: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (pkts_sent !== 8'h0 || credit_err !== 1'b0) begin fails++; $display("[TB] FAIL rst_counters: got pkts=%0d err=%b expected 0 0", pkts_sent, credit_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) clock_cycle();
    checks++; if (busy !== 1'b0 || cap_mark.size() != 0) begin fails++; $display("[TB] FAIL idle: got busy=%b flits=%0d expected 0 0", busy, cap_mark.size()); end
    kick(1, 1, 4, 0, 0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_pkts_done: got done=%b busy=%b expected 1 0", done, busy); end
    repeat (3) clock_cycle();
    checks++; if (cap_mark.size() != 0 || done !== 1'b1) begin fails++; $display("[TB] FAIL zero_pkts_quiet: got flits=%0d done=%b expected 0 1", cap_mark.size(), done); end
  endtask

  task automatic test_single_packet();
    auto_credit = 1;
    kick(2, 3, 4, 0, 1);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL start_busy: got %b expected 1", busy); end
    run_until_done(50);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL single_done: got done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (cap_mark.size() != exp_mark.size()) begin fails++; $display("[TB] FAIL single_count: got %0d expected %0d", cap_mark.size(), exp_mark.size()); end
    for (int k = 0; k < exp_mark.size() && k < cap_mark.size(); k++) begin
      checks++;
      if (cap_mark[k] !== exp_mark[k] || cap_data[k] !== exp_data[k] || cap_cyc[k] !== exp_cyc[k]) begin
        fails++;
        $display("[TB] FAIL single_flit%0d: got %b/%h@%0d expected %b/%h@%0d", k, cap_mark[k], cap_data[k], cap_cyc[k], exp_mark[k], exp_data[k], exp_cyc[k]);
      end
    end
    checks++; if (cap_data.size() > 0 && cap_data[0] !== 32'h2380_0000) begin fails++; $display("[TB] FAIL single_header: got %h expected 23800000", cap_data[0]); end
    checks++; if (pkts_sent !== 8'd1) begin fails++; $display("[TB] FAIL single_pkts: got %0d expected 1", pkts_sent); end
  endtask

  task automatic test_stall();
    auto_credit = 0;
    kick(5, 6, 6, 0, 1);
    repeat (10) clock_cycle();
    checks++; if (cap_mark.size() != BD) begin fails++; $display("[TB] FAIL stall_count: got %0d expected %0d", cap_mark.size(), BD); end
    checks++; if (diff_pair_out !== 2'b00 || busy !== 1'b1) begin fails++; $display("[TB] FAIL stall_idle: got marker=%b busy=%b expected 00 1", diff_pair_out, busy); end
    checks++; if (channel_out !== exp_data[BD-1]) begin fails++; $display("[TB] FAIL stall_hold: got %h expected %h", channel_out, exp_data[BD-1]); end
    credit_in = 1'b1;
    clock_cycle();
    checks++; if (cap_mark.size() != BD) begin fails++; $display("[TB] FAIL credit_same_cycle: got %0d flits expected %0d", cap_mark.size(), BD); end
    clock_cycle();
    checks++; if (cap_mark.size() != BD + 1) begin fails++; $display("[TB] FAIL credit_next_cycle: got %0d flits expected %0d", cap_mark.size(), BD + 1); end
    credit_in = 1'b1;
    clock_cycle();
    run_until_done(10);
    checks++; if (done !== 1'b1 || cap_mark.size() != exp_mark.size()) begin fails++; $display("[TB] FAIL stall_finish: got done=%b flits=%0d expected 1 %0d", done, cap_mark.size(), exp_mark.size()); end
    for (int k = 0; k < exp_mark.size() && k < cap_mark.size(); k++) begin
      checks++;
      if (cap_mark[k] !== exp_mark[k] || cap_data[k] !== exp_data[k]) begin
        fails++;
        $display("[TB] FAIL stall_flit%0d: got %b/%h expected %b/%h", k, cap_mark[k], cap_data[k], exp_mark[k], exp_data[k]);
      end
    end
    for (int k = 0; k < BD; k++) begin
      credit_in = 1'b1;
      clock_cycle();
    end
    checks++; if (credit_err !== 1'b0) begin fails++; $display("[TB] FAIL stall_refill_err: got %b expected 0", credit_err); end
  endtask

  task automatic test_gap();
    bit poked = 0;
    auto_credit = 1;
    kick(7, 1, 3, 3, 2);
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      if (!poked && cap_mark.size() == 3) begin
        start = 1'b1; cfg_num_pkts = '0; cfg_dst_x = '0; poked = 1;
      end
      clock_cycle();
    end
    checks++; if (done !== 1'b1 || pkts_sent !== 8'd2) begin fails++; $display("[TB] FAIL gap_done: got done=%b pkts=%0d expected 1 2", done, pkts_sent); end
    checks++; if (cap_mark.size() != exp_mark.size()) begin fails++; $display("[TB] FAIL gap_count: got %0d expected %0d", cap_mark.size(), exp_mark.size()); end
    for (int k = 0; k < exp_mark.size() && k < cap_mark.size(); k++) begin
      checks++;
      if (cap_mark[k] !== exp_mark[k] || cap_data[k] !== exp_data[k] || cap_cyc[k] !== exp_cyc[k]) begin
        fails++;
        $display("[TB] FAIL gap_flit%0d: got %b/%h@%0d expected %b/%h@%0d", k, cap_mark[k], cap_data[k], cap_cyc[k], exp_mark[k], exp_data[k], exp_cyc[k]);
      end
    end
    if (cap_mark.size() >= 4) begin
      checks++; if (cap_cyc[3] - cap_cyc[2] != 4) begin fails++; $display("[TB] FAIL gap_spacing: got %0d expected 4", cap_cyc[3] - cap_cyc[2]); end
      checks++; if (cap_data[3][7:0] !== 8'd1) begin fails++; $display("[TB] FAIL gap_seq: got %0d expected 1", cap_data[3][7:0]); end
    end
  endtask

  task automatic test_credit_err();
    auto_credit = 0;
    kick(3, 3, 6, 0, 1);
    for (int k = 0; k < 6; k++) begin
      credit_in = 1'b1;
      clock_cycle();
    end
    checks++; if (done !== 1'b1 || cap_mark.size() != 6) begin fails++; $display("[TB] FAIL b2b_count: got done=%b flits=%0d expected 1 6", done, cap_mark.size()); end
    for (int k = 0; k < exp_mark.size() && k < cap_mark.size(); k++) begin
      checks++;
      if (cap_mark[k] !== exp_mark[k] || cap_data[k] !== exp_data[k] || cap_cyc[k] !== exp_cyc[k]) begin
        fails++;
        $display("[TB] FAIL b2b_flit%0d: got %b/%h@%0d expected %b/%h@%0d", k, cap_mark[k], cap_data[k], cap_cyc[k], exp_mark[k], exp_data[k], exp_cyc[k]);
      end
    end
    repeat (3) clock_cycle();
    checks++; if (credit_err !== 1'b0) begin fails++; $display("[TB] FAIL balanced_err: got %b expected 0", credit_err); end
    credit_in = 1'b1;
    clock_cycle();
    checks++; if (credit_err !== 1'b1) begin fails++; $display("[TB] FAIL overflow_err: got %b expected 1", credit_err); end
    repeat (5) clock_cycle();
    checks++; if (credit_err !== 1'b1) begin fails++; $display("[TB] FAIL sticky_err: got %b expected 1", credit_err); end
  endtask

  task automatic test_mid_reset();
    auto_credit = 1;
    kick(4, 4, 5, 0, 2);
    for (int i = 0; i < 20 && cap_mark.size() < 3; i++) clock_cycle();
    checks++; if (cap_mark.size() != 3) begin fails++; $display("[TB] FAIL pre_reset_flits: got %0d expected 3", cap_mark.size()); end
    #2;
    rst = 1'b1;
    credit_in = 1'b0;
    #1;
    checks++; if (channel_out !== 32'h0 || diff_pair_out !== 2'b00) begin fails++; $display("[TB] FAIL async_rst_flit: got %h/%b expected 0/00", channel_out, diff_pair_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pkts_sent !== 8'h0 || credit_err !== 1'b0) begin fails++; $display("[TB] FAIL async_rst_status: got busy=%b done=%b pkts=%0d err=%b expected 0 0 0 0", busy, done, pkts_sent, credit_err); end
    @(negedge clk);
    rst = 1'b0;
    ref_lfsr = SEED;
    clear_capture();
    repeat (6) clock_cycle();
    checks++; if (cap_mark.size() != 0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL abandoned: got flits=%0d busy=%b expected 0 0", cap_mark.size(), busy); end
    kick(4, 4, 3, 0, 1);
    run_until_done(30);
    checks++; if (done !== 1'b1 || cap_mark.size() != exp_mark.size()) begin fails++; $display("[TB] FAIL post_rst_run: got done=%b flits=%0d expected 1 %0d", done, cap_mark.size(), exp_mark.size()); end
    for (int k = 0; k < exp_mark.size() && k < cap_mark.size(); k++) begin
      checks++;
      if (cap_mark[k] !== exp_mark[k] || cap_data[k] !== exp_data[k] || cap_cyc[k] !== exp_cyc[k]) begin
        fails++;
        $display("[TB] FAIL post_rst_flit%0d: got %b/%h@%0d expected %b/%h@%0d", k, cap_mark[k], cap_data[k], cap_cyc[k], exp_mark[k], exp_data[k], exp_cyc[k]);
      end
    end
  endtask

  task automatic test_random();
    int dx, dy, len, gap, num;
    auto_credit = 1;
    for (int r = 0; r < 5; r++) begin
      dx  = int'($urandom_range(0, 15));
      dy  = int'($urandom_range(0, 15));
      len = int'($urandom_range(0, 6));
      gap = int'($urandom_range(0, 3));
      num = int'($urandom_range(1, 3));
      kick(dx, dy, len, gap, num);
      run_until_done(200);
      checks++; if (done !== 1'b1 || pkts_sent !== LEN_W'(num)) begin fails++; $display("[TB] FAIL rand%0d_done: got done=%b pkts=%0d expected 1 %0d", r, done, pkts_sent, num); end
      checks++; if (cap_mark.size() != exp_mark.size()) begin fails++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", r, cap_mark.size(), exp_mark.size()); end
      for (int k = 0; k < exp_mark.size() && k < cap_mark.size(); k++) begin
        checks++;
        if (cap_mark[k] !== exp_mark[k] || cap_data[k] !== exp_data[k] || cap_cyc[k] !== exp_cyc[k]) begin
          fails++;
          $display("[TB] FAIL rand%0d_flit%0d: got %b/%h@%0d expected %b/%h@%0d", r, k, cap_mark[k], cap_data[k], cap_cyc[k], exp_mark[k], exp_data[k], exp_cyc[k]);
        end
      end
    end
  endtask

  // Scenario sequence, ending with the single summary line.
  initial begin
    test_reset();
    test_single_packet();
    test_stall();
    test_gap();
    test_random();
    test_credit_err();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
